muldiv_unit: RTL

Parametrised multi-cycle multiply/divide unit for the execute stage. It replaces the ad-hoc start/ready wiring around separate multiplier and divider instances with one unit that has a single handshake, stall-aware result holding, and flush abort. It generalises operand width and multiplier latency, and adds multiply-accumulate/subtract into HI/LO plus explicit divide-by-zero reporting. The pipeline stalls E while `busy_o` is high and writes `result_o` to HI/LO on `done_o`.

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/muldiv_if.sv | 34 +++
 rtl/muldiv_div_iter.sv | 57 +++++
 rtl/muldiv_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared types and helpers for the multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MADD  = 3'd4,
    MADDU = 3'd5,
    MSUB  = 3'd6,
    MSUBU = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Divide ops are the only ones that take the iterative path
  function automatic logic is_div(input op_e op);
    return (op == DIV) || (op == DIVU);
  endfunction

  // Even encodings are the signed flavours
  function automatic logic is_signed(input op_e op);
    return (op[0] == 1'b0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_if
//  Description : Request/result bundle between execute stage and muldiv_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic               start_i;
  op_e                op_i;
  logic [WIDTH-1:0]   src_a_i;
  logic [WIDTH-1:0]   src_b_i;
  logic [2*WIDTH-1:0] hilo_i;
  logic               stall_i;
  logic               flush_i;
  logic               busy_o;
  logic               done_o;
  logic [2*WIDTH-1:0] result_o;
  logic               div_by_zero_o;

  modport slave (
    input  start_i, op_i, src_a_i, src_b_i, hilo_i, stall_i, flush_i,
    output busy_o, done_o, result_o, div_by_zero_o
  );

  modport master (
    output start_i, op_i, src_a_i, src_b_i, hilo_i, stall_i, flush_i,
    input  busy_o, done_o, result_o, div_by_zero_o
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : div_iter
//  Description : Unsigned restoring radix-2 divider, one quotient bit/step.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;

  // Trial subtraction; the extra top bit doubles as the borrow flag
  always_comb begin
    w_shift = {rem_q, quo_q[WIDTH-1]};
    w_diff  = w_shift - {1'b0, dvs_q};
  end

  // Quotient shifts in from the bottom while the dividend shifts out the top
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
    end else if (step_i) begin
      if (!w_diff[WIDTH]) begin
        rem_q <= w_diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= w_shift[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Multi-cycle multiply / multiply-accumulate / divide unit
//                with single handshake, stall hold and flush abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam int             CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  state_e               state_q;
  op_e                  op_q;
  logic [WIDTH-1:0]     a_q;
  logic [2*WIDTH-1:0]   hilo_q;
  logic                 a_neg_q;
  logic                 q_neg_q;
  logic                 b_zero_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 dbz_q;
  logic [2*WIDTH-1:0]   result_q;

  logic                 w_accept;
  logic                 w_sgn;
  logic [2*WIDTH-1:0]   w_a_ext;
  logic [2*WIDTH-1:0]   w_b_ext;
  logic [2*WIDTH-1:0]   w_prod_now;
  logic [WIDTH-1:0]     w_a_abs;
  logic [WIDTH-1:0]     w_b_abs;
  logic [2*WIDTH-1:0]   w_mul_prod;
  logic                 w_mul_vld;
  logic                 w_div_step;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;
  logic [WIDTH-1:0]     w_quo_fix;
  logic [WIDTH-1:0]     w_rem_fix;

  function automatic logic [2*WIDTH-1:0] f_acc(input logic [2*WIDTH-1:0] prod,
                                               input logic [2*WIDTH-1:0] hilo,
                                               input op_e op);
    case (op)
      MADD, MADDU: return hilo + prod;
      MSUB, MSUBU: return hilo - prod;
      default:     return prod;
    endcase
  endfunction

  // Operand conditioning: sign/zero extension for the product, magnitudes for divide
  always_comb begin
    w_accept   = (state_q == S_IDLE) && bus.start_i && !bus.flush_i;
    w_sgn      = is_signed(bus.op_i);
    w_a_ext    = {{WIDTH{w_sgn & bus.src_a_i[WIDTH-1]}}, bus.src_a_i};
    w_b_ext    = {{WIDTH{w_sgn & bus.src_b_i[WIDTH-1]}}, bus.src_b_i};
    w_prod_now = w_a_ext * w_b_ext;
    w_a_abs    = (w_sgn && bus.src_a_i[WIDTH-1]) ? -bus.src_a_i : bus.src_a_i;
    w_b_abs    = (w_sgn && bus.src_b_i[WIDTH-1]) ? -bus.src_b_i : bus.src_b_i;
    w_div_step = (state_q == S_DIV) && (cnt_q != LAST_CNT) && !bus.flush_i;
    w_quo_fix  = q_neg_q ? -w_quo : w_quo;
    w_rem_fix  = a_neg_q ? -w_rem : w_rem;
  end

  // The final product register is result_q itself, so MUL_STAGES-1 stages live here
  generate
    if (MUL_STAGES > 1) begin : g_pipe
      logic [2*WIDTH-1:0] pipe_q [MUL_STAGES-1];
      logic [MUL_STAGES-2:0] vld_q;

      // Product pipeline; flush kills every in-flight valid bit
      always_ff @(posedge clk) begin
        pipe_q[0] <= w_prod_now;
        for (int i = 1; i < MUL_STAGES - 1; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
        if (rst) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= w_accept && !is_div(bus.op_i);
          for (int i = 1; i < MUL_STAGES - 1; i++) begin
            vld_q[i] <= vld_q[i-1] && !bus.flush_i;
          end
        end
      end

      assign w_mul_prod = pipe_q[MUL_STAGES-2];
      assign w_mul_vld  = vld_q[MUL_STAGES-2];
    end else begin : g_nopipe
      assign w_mul_prod = w_prod_now;
      assign w_mul_vld  = 1'b0;
    end
  endgenerate

  div_iter #(.WIDTH(WIDTH)) u_div_iter (
    .clk         (clk),
    .rst         (rst),
    .load_i      (w_accept && is_div(bus.op_i)),
    .step_i      (w_div_step),
    .dividend_i  (w_a_abs),
    .divisor_i   (w_b_abs),
    .quotient_o  (w_quo),
    .remainder_o (w_rem)
  );

  // Control FSM with registered handshake outputs and result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= MULT;
      a_q      <= '0;
      hilo_q   <= '0;
      a_neg_q  <= 1'b0;
      q_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            op_q     <= bus.op_i;
            a_q      <= bus.src_a_i;
            hilo_q   <= bus.hilo_i;
            a_neg_q  <= w_sgn && bus.src_a_i[WIDTH-1];
            q_neg_q  <= w_sgn && (bus.src_a_i[WIDTH-1] ^ bus.src_b_i[WIDTH-1]);
            b_zero_q <= (bus.src_b_i == '0);
            busy_q   <= 1'b1;
            dbz_q    <= 1'b0;
            if (is_div(bus.op_i)) begin
              // A zero divisor jumps straight to the finishing cycle
              cnt_q   <= (bus.src_b_i == '0) ? LAST_CNT : '0;
              state_q <= S_DIV;
            end else if (MUL_STAGES == 1) begin
              result_q <= f_acc(w_prod_now, bus.hilo_i, bus.op_i);
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              state_q <= S_MUL;
            end
          end
        end
        S_MUL: begin
          if (bus.flush_i) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (w_mul_vld) begin
            result_q <= f_acc(w_mul_prod, hilo_q, op_q);
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DIV: begin
          if (bus.flush_i) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (cnt_q == LAST_CNT) begin
            if (b_zero_q) begin
              result_q <= {a_q, {WIDTH{1'b1}}};
              dbz_q    <= 1'b1;
            end else begin
              result_q <= {w_rem_fix, w_quo_fix};
            end
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.flush_i || !bus.stall_i) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;
  assign bus.result_o      = result_q;
  assign bus.div_by_zero_o = dbz_q;

endmodule
`default_nettype wire
